// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// default bus widths and requester indices.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  function automatic state_t lock_state(input logic port);
    return port ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side pins of the arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              p0_req;
  logic              p0_we;
  logic              p0_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic              p1_lock;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              lock_timeout;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output lock_timeout, busy
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  lock_timeout, busy
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// port that did not win last time.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing one 256x8 data memory port between the CPU and the
// debug/DMA loader, with locked multi-cycle sequences and registered read return.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  state_t            state, state_nxt;
  logic              last_gnt, last_nxt;
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic              timeout_nxt;
  logic              timeout_q;

  logic [1:0]        req_v;
  logic [1:0]        lock_v;
  logic [1:0]        gnt;
  logic              own;
  logic              pick_win;
  logic              pick_vld;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;
  logic              re_mux;

  logic              rvalid0_p1, rvalid1_p1;
  logic [DATA_W-1:0] rdata0_p1, rdata1_p1;

  assign req_v  = {bus.p1_req,  bus.p0_req};
  assign lock_v = {bus.p1_lock, bus.p0_lock};
  assign own    = (state == LOCK1) ? REQ_DMA : REQ_CPU;

  dmem_rr_pick u_pick (
    .req    (req_v),
    .last   (last_gnt),
    .winner (pick_win),
    .valid  (pick_vld)
  );

  // Grant decision and next-state: combinational in the request cycle.
  always_comb begin
    gnt         = 2'b00;
    state_nxt   = state;
    last_nxt    = last_gnt;
    cnt_nxt     = lock_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt[pick_win] = 1'b1;
          last_nxt      = pick_win;
          if (lock_v[pick_win]) begin
            state_nxt = lock_state(pick_win);
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!req_v[own]) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!lock_v[own]) begin
          gnt[own]  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (lock_cnt < LOCK_MAX_C) begin
          gnt[own]  = 1'b1;
          cnt_nxt   = lock_cnt + CNT_W'(1);
        end else begin
          // Lock held too long: refuse the access and hand the next tie away.
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
          last_nxt    = own;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (rst) gnt = 2'b00;
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    re_mux    = 1'b0;
    if (gnt[REQ_CPU]) begin
      addr_mux  = bus.p0_addr;
      wdata_mux = bus.p0_wdata;
      we_mux    = bus.p0_we;
      re_mux    = ~bus.p0_we;
    end else if (gnt[REQ_DMA]) begin
      addr_mux  = bus.p1_addr;
      wdata_mux = bus.p1_wdata;
      we_mux    = bus.p1_we;
      re_mux    = ~bus.p1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lock_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_nxt;
      lock_cnt  <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Read return: captured at the edge that ends the granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      rvalid0_p1 <= gnt[REQ_CPU] & ~bus.p0_we;
      rvalid1_p1 <= gnt[REQ_DMA] & ~bus.p1_we;
      if (gnt[REQ_CPU] && !bus.p0_we) rdata0_p1 <= bus.mem_rdata;
      if (gnt[REQ_DMA] && !bus.p1_we) rdata1_p1 <= bus.mem_rdata;
    end
  end

  assign bus.p0_gnt       = gnt[REQ_CPU];
  assign bus.p1_gnt       = gnt[REQ_DMA];
  assign bus.p0_rvalid    = rvalid0_p1;
  assign bus.p1_rvalid    = rvalid1_p1;
  assign bus.p0_rdata     = rdata0_p1;
  assign bus.p1_rdata     = rdata1_p1;
  assign bus.mem_addr     = addr_mux;
  assign bus.mem_wdata    = wdata_mux;
  assign bus.mem_we       = we_mux;
  assign bus.mem_re       = re_mux;
  assign bus.lock_timeout = timeout_q;
  assign bus.busy         = (state != IDLE) | (|gnt);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter: a bench-side RAM feeds mem_rdata, and a
// shadow copy plus a read queue predicts every grant, strobe and returned byte.
module tb_dmem_arbiter;

  logic clk;
  logic rst;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram    [256];
  logic [7:0] shadow [256];

  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    bit         port;
    logic [7:0] data;
  } rd_t;
  rd_t rd_q[$];

  int errors = 0;
  int checks = 0;

  task automatic setp(input bit n, input bit req, input bit we, input bit lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
    if (n == 1'b0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_lock = lock;
      bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_lock = lock;
      bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic idle_inputs();
    setp(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    setp(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // One clock: checks the combinational grant/memory drive, then the registered outputs.
  task automatic step(input logic eg0, input logic eg1, input logic eb, input logic eto);
    logic [7:0] ea, ed;
    logic       ewe, ere;
    rd_t        e;
    #1;
    ea = 8'h00; ed = 8'h00; ewe = 1'b0; ere = 1'b0;
    if (eg0) begin
      ea = bus.p0_addr; ed = bus.p0_wdata; ewe = bus.p0_we; ere = ~bus.p0_we;
    end else if (eg1) begin
      ea = bus.p1_addr; ed = bus.p1_wdata; ewe = bus.p1_we; ere = ~bus.p1_we;
    end
    checks++; if (bus.p0_gnt !== eg0) begin errors++; $display("FAIL p0_gnt: got %b want %b at %0t", bus.p0_gnt, eg0, $time); end
    checks++; if (bus.p1_gnt !== eg1) begin errors++; $display("FAIL p1_gnt: got %b want %b at %0t", bus.p1_gnt, eg1, $time); end
    checks++; if (bus.mem_we !== ewe) begin errors++; $display("FAIL mem_we: got %b want %b at %0t", bus.mem_we, ewe, $time); end
    checks++; if (bus.mem_re !== ere) begin errors++; $display("FAIL mem_re: got %b want %b at %0t", bus.mem_re, ere, $time); end
    checks++; if (bus.mem_addr !== ea) begin errors++; $display("FAIL mem_addr: got %h want %h at %0t", bus.mem_addr, ea, $time); end
    checks++; if (bus.mem_wdata !== ed) begin errors++; $display("FAIL mem_wdata: got %h want %h at %0t", bus.mem_wdata, ed, $time); end
    checks++; if (bus.busy !== eb) begin errors++; $display("FAIL busy: got %b want %b at %0t", bus.busy, eb, $time); end
    if (ere) rd_q.push_back('{port: eg1, data: shadow[ea]});
    if (ewe) shadow[ea] = ed;
    @(posedge clk); #1;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      if (e.port == 1'b0) begin
        checks++; if (bus.p0_rvalid !== 1'b1 || bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_p0read: got p0=%b p1=%b want p0=1 p1=0 at %0t", bus.p0_rvalid, bus.p1_rvalid, $time); end
        checks++; if (bus.p0_rdata !== e.data) begin errors++; $display("FAIL p0_rdata: got %h want %h at %0t", bus.p0_rdata, e.data, $time); end
      end else begin
        checks++; if (bus.p1_rvalid !== 1'b1 || bus.p0_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_p1read: got p0=%b p1=%b want p0=0 p1=1 at %0t", bus.p0_rvalid, bus.p1_rvalid, $time); end
        checks++; if (bus.p1_rdata !== e.data) begin errors++; $display("FAIL p1_rdata: got %h want %h at %0t", bus.p1_rdata, e.data, $time); end
      end
    end else begin
      checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_idle: got p0=%b p1=%b want 0 0 at %0t", bus.p0_rvalid, bus.p1_rvalid, $time); end
    end
    checks++; if (bus.lock_timeout !== eto) begin errors++; $display("FAIL lock_timeout: got %b want %b at %0t", bus.lock_timeout, eto, $time); end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    rd_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setp(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    setp(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'h33);
    #2;
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b%b want 00", bus.p1_gnt, bus.p0_gnt); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin errors++; $display("FAIL rst_mem: got we=%b re=%b want 0 0", bus.mem_we, bus.mem_re); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", bus.p1_rvalid, bus.p0_rvalid); end
    checks++; if (bus.p0_rdata !== 8'h00 || bus.p1_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h %h want 00 00", bus.p0_rdata, bus.p1_rdata); end
    checks++; if (bus.lock_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", bus.lock_timeout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    setp(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.p0_rdata !== 8'hA5) begin errors++; $display("FAIL first_read: got %h want a5", bus.p0_rdata); end
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.p0_rdata !== 8'hA5) begin errors++; $display("FAIL rdata_hold: got %h want a5", bus.p0_rdata); end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      setp(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 8'h00);
      setp(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h48 + i), 8'(8'hC0 + i));
      if (i % 2 == 0) step(1'b1, 1'b0, 1'b1, 1'b0);
      else            step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic test_rmw();
    setp(1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    setp(1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    setp(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h21);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    setp(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (ram[8'h20] !== 8'h21) begin errors++; $display("FAIL rmw_write: got %h want 21", ram[8'h20]); end
    idle_inputs();
  endtask

  task automatic test_lock_timeout();
    setp(1'b0, 1'b1, 1'b0, 1'b1, 8'h50, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    setp(1'b1, 1'b1, 1'b0, 1'b0, 8'h51, 8'h00);
    for (int i = 0; i < 3; i++) begin
      setp(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h52 + i), 8'h00);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    setp(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h77);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    setp(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.p1_rdata !== 8'h77) begin errors++; $display("FAIL wr_then_rd: got %h want 77", bus.p1_rdata); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    setp(1'b1, 1'b1, 1'b0, 1'b1, 8'h60, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    setp(1'b0, 1'b1, 1'b0, 1'b0, 8'h61, 8'h00);
    setp(1'b1, 1'b1, 1'b0, 1'b1, 8'h62, 8'h00);
    #1;
    checks++; if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin errors++; $display("FAIL midlock_rst_gnt: got %b%b want 00", bus.p1_gnt, bus.p0_gnt); end
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL midlock_rst_mem: got we=%b re=%b want 0 0", bus.mem_we, bus.mem_re); end
    @(posedge clk); #1;
    checks++; if (bus.p1_rvalid !== 1'b0) begin errors++; $display("FAIL midlock_rvalid: got %b want 0", bus.p1_rvalid); end
    checks++; if (bus.p1_rdata !== 8'h00) begin errors++; $display("FAIL midlock_rdata: got %h want 00", bus.p1_rdata); end
    rst = 1'b0;
    rd_q.delete();
    setp(1'b1, 1'b1, 1'b0, 1'b0, 8'h62, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    <= 8'(i * 3 + 1);
      shadow[i]  = 8'(i * 3 + 1);
    end
    ram[8'h10]    <= 8'hA5;
    shadow[8'h10]  = 8'hA5;
    rst = 1'b1;
    idle_inputs();

    test_reset();
    test_single_read();
    test_alternate();
    test_rmw();
    test_lock_timeout();
    test_back_to_back();
    test_reset_mid_lock();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 256×8 data memory. It shares the single memory port between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader). It grants one access per cycle with round-robin fairness and supports locked multi-cycle sequences such as read-modify-write. It also registers read data back to the winning requester. It sits between the requesters and the data memory's addr/write_data/write_en/read_en/read_data pins.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- LOCK_MAX, 16, maximum consecutive granted cycles under lock (≥2)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- pN_req  in  1  requester N (N=0,1) wants an access this cycle
- pN_we  in  1  1 = write, 0 = read
- pN_lock  in  1  keep ownership after this access
- pN_addr  in  ADDR_W  access address
- pN_wdata  in  DATA_W  write data
- pN_gnt  out  1  combinational; access performed this cycle
- pN_rvalid  out  1  registered one-cycle pulse, read data ready
- pN_rdata  out  DATA_W  registered read data, held until next read by N
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_we  out  1  to memory write_en
- mem_re  out  1  to memory read_en
- mem_rdata  in  DATA_W  from memory read_data (combinational read)
- lock_timeout  out  1  registered one-cycle pulse, lock forcibly broken
- busy  out  1  combinational; FSM not IDLE or any gnt asserted

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Registers: state, last_gnt (1 bit), lock_cnt ($clog2(LOCK_MAX+1) bits).
- IDLE: one requester asserts req → it is granted. Both assert req → grant port ≠ last_gnt. Update last_gnt to the winner.
- Granted with pN_lock=1 in IDLE → next state LOCKN, lock_cnt=1.
- LOCKN: only port N can be granted; other port's gnt=0 regardless of req.
  - pN_req=1, lock=1, lock_cnt<LOCK_MAX → grant, lock_cnt+1, stay.
  - pN_req=1, lock=0 → grant (final access), → IDLE.
  - pN_req=0 → no grant this cycle, → IDLE.
  - pN_req=1, lock=1, lock_cnt==LOCK_MAX → no grant, → IDLE; lock_timeout pulses next cycle; last_gnt=N so the other port wins the next tie.
- Memory drive: mem_* mirror the granted port. mem_we = pN_we & gnt; mem_re = ~pN_we & gnt. No grant → mem_we=mem_re=0, mem_addr/mem_wdata=0.
- Read return: at the edge ending a granted read, pN_rdata ← mem_rdata and pN_rvalid ← 1. Otherwise rvalid ← 0 and rdata holds.
- Write and read to the same address by different ports in consecutive cycles: the read sees the new data.

## Timing
- Grant latency 0: gnt is combinational from req and state, in the same cycle.
- Read data latency 1: rvalid/rdata appear the cycle after gnt.
- Write commits at the edge ending the grant cycle.
- Throughput: one access per cycle. With both requesting unlocked, grants alternate 0,1,0,1.
- Reset values: state=IDLE, last_gnt=1 (port 0 wins the first tie), lock_cnt=0, p0/p1_rvalid=0, p0/p1_rdata=0, lock_timeout=0.
- While rst=1: all gnt=0, mem_we=mem_re=0.
- Reset mid-lock returns to IDLE and discards any pending rvalid.

## Structure
- Package dmem_pkg: state enum typedef (IDLE, LOCK0, LOCK1), ADDR_W/DATA_W defaults, requester-index constants.
- One sub-module: dmem_rr_pick, a 2-way round-robin picker (req[1:0], last → winner, valid).
- The arbiter instantiates the picker and contains the FSM, lock counter, and read-return registers.

## Test plan
- Reset release; p0 read addr 0x10 (mem=0xA5) → p0_gnt same cycle, p0_rvalid=1 and p0_rdata=0xA5 next cycle.
- Both request every cycle, unlocked, 6 cycles → grants 0,1,0,1,0,1; mem_we/mem_re match each winner's we.
- p1 locked RMW: read 0x20 with lock, then write 0x21 with lock=0; p0 requesting throughout → p0_gnt=0 for both cycles, p0 granted on the third cycle, mem[0x20]=0x21.
- LOCK_MAX=4, p0 holds lock continuously, p1 requesting → 4 p0 grants, 5th cycle no grant, lock_timeout pulse, p1 granted on the next cycle.
- p0 write 0x3C→0x77 then p1 read 0x3C in the next cycle → p1_rdata=0x77.
- Assert rst while in LOCK1 with a read granted → no p1_rvalid, state IDLE, the first post-reset tie goes to p0.
